// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// keypad_entry_ctrl : debounced keypad decode into a BCD countdown preset
// Revision 1.0 - initial release
// ============================================================================
module keypad_entry_ctrl #(
  parameter int NDIGITS  = 4,
  parameter int DEBOUNCE = 8
) (
  input  logic                   scan_clk,
  input  logic                   rst_n,
  input  logic                   keydown_i,
  input  logic [3:0]             key_i,
  input  logic                   start_ack_i,
  output logic [4*NDIGITS-1:0]   entry_o,
  output logic [3:0]             digit_count_o,
  output logic                   start_req_o,
  output logic                   key_valid_o,
  output logic [3:0]             key_code_o,
  output logic                   err_o
);

  localparam int          EW    = 4 * NDIGITS;
  localparam int          CW    = $clog2(DEBOUNCE + 1);
  localparam logic [CW:0] C_DB  = (CW+1)'(DEBOUNCE);
  localparam logic [3:0]  C_ND  = 4'(NDIGITS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS    = 3'd1,
    S_HELD     = 3'd2,
    S_REL      = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [EW-1:0]  entry_q;
  logic [3:0]     count_q;
  logic           start_req_q;
  logic           key_valid_q;
  logic [3:0]     key_code_q;
  logic           err_q;
  logic           armed_q;

  logic [CW:0]    w_cnt_inc;
  logic           w_db_hit;
  logic [EW-1:0]  w_key_ext;
  logic [EW-1:0]  w_shift_in;

  // cnt_q counts stable samples already seen; this sample would make it w_cnt_inc
  assign w_cnt_inc  = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign w_db_hit   = (w_cnt_inc >= C_DB);
  assign w_key_ext  = EW'(key_i);
  assign w_shift_in = (entry_q << 4) | w_key_ext;

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      entry_q     <= '0;
      count_q     <= '0;
      start_req_q <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      // A key held across reset must be released before it can count as a press
      if (!keydown_i) armed_q <= 1'b1;

      case (state_q)
        S_IDLE, S_PRESS: begin
          if (!keydown_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if ((state_q == S_PRESS) || armed_q) begin
            if (!w_db_hit) begin
              state_q <= S_PRESS;
              cnt_q   <= w_cnt_inc[CW-1:0];
            end else begin
              state_q     <= S_HELD;
              cnt_q       <= '0;
              key_valid_q <= 1'b1;
              key_code_q  <= key_i;
              if (key_i < 4'd10) begin
                if (count_q < C_ND) begin
                  entry_q <= w_shift_in;
                  count_q <= count_q + 4'd1;
                end else begin
                  err_q <= 1'b1;
                end
              end else if (key_i == 4'd10) begin
                if (count_q != 4'd0) begin
                  start_req_q <= 1'b1;
                  state_q     <= S_WAIT_ACK;
                end else begin
                  err_q <= 1'b1;
                end
              end else if (key_i == 4'd11) begin
                entry_q <= '0;
                count_q <= '0;
              end else if (key_i == 4'd12) begin
                if (count_q != 4'd0) begin
                  entry_q <= entry_q >> 4;
                  count_q <= count_q - 4'd1;
                end else begin
                  err_q <= 1'b1;
                end
              end
            end
          end
        end

        S_HELD: begin
          if (!keydown_i) begin
            state_q <= S_REL;
            cnt_q   <= (CW)'(1);
          end
        end

        S_REL: begin
          if (keydown_i) begin
            state_q <= S_HELD;
            cnt_q   <= '0;
          end else if (w_db_hit) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= w_cnt_inc[CW-1:0];
          end
        end

        S_WAIT_ACK: begin
          if (start_ack_i) begin
            start_req_q <= 1'b0;
            entry_q     <= '0;
            count_q     <= '0;
            state_q     <= keydown_i ? S_HELD : S_REL;
            cnt_q       <= keydown_i ? '0 : (CW)'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign entry_o       = entry_q;
  assign digit_count_o = count_q;
  assign start_req_o   = start_req_q;
  assign key_valid_o   = key_valid_q;
  assign key_code_o    = key_code_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// tb_keypad_entry_ctrl : directed bench for keypad_entry_ctrl (NDIGITS=4, DEBOUNCE=8)
// ============================================================================
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        keydown;
  logic [3:0]  key;
  logic        start_ack;
  logic [15:0] entry;
  logic [3:0]  digit_count;
  logic        start_req;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        err;

  int total = 0;
  int bad   = 0;
  int kv_cnt  = 0;
  int err_cnt = 0;

  keypad_entry_ctrl #(.NDIGITS(4), .DEBOUNCE(8)) dut (
    .scan_clk      (clk),
    .rst_n         (rst_n),
    .keydown_i     (keydown),
    .key_i         (key),
    .start_ack_i   (start_ack),
    .entry_o       (entry),
    .digit_count_o (digit_count),
    .start_req_o   (start_req),
    .key_valid_o   (key_valid),
    .key_code_o    (key_code),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_valid) kv_cnt  <= kv_cnt + 1;
    if (err)       err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key     = k;
    keydown = 1'b1;
    repeat (10) @(negedge clk);
    keydown = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_entry"}, 32'(entry), 32'h0);
    chk({tag, "_count"}, 32'(digit_count), 32'h0);
    chk({tag, "_req"},   32'(start_req), 32'h0);
    chk({tag, "_kv"},    32'(key_valid), 32'h0);
    chk({tag, "_code"},  32'(key_code), 32'h0);
    chk({tag, "_err"},   32'(err), 32'h0);
  endtask

  initial begin
    int kv0;
    int er0;
    int hi;
    rst_n = 1'b0; keydown = 1'b0; key = 4'd0; start_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // digits 1,2,3
    kv0 = kv_cnt; er0 = err_cnt;
    press(4'd1); press(4'd2); press(4'd3);
    chk("t1_entry", 32'(entry), 32'h0123);
    chk("t1_count", 32'(digit_count), 32'd3);
    chk("t1_kv",    32'(kv_cnt - kv0), 32'd3);
    chk("t1_code",  32'(key_code), 32'd3);
    chk("t1_err",   32'(err_cnt - er0), 32'd0);

    // 5-cycle glitch is rejected
    kv0 = kv_cnt;
    key = 4'd7; keydown = 1'b1;
    repeat (5) @(negedge clk);
    keydown = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_kv",    32'(kv_cnt - kv0), 32'd0);
    chk("t2_entry", 32'(entry), 32'h0123);

    // backspace then ignored code 13 then clear
    press(4'd12);
    chk("bs_entry", 32'(entry), 32'h0012);
    chk("bs_count", 32'(digit_count), 32'd2);
    kv0 = kv_cnt; er0 = err_cnt;
    press(4'd13);
    chk("ign_kv",    32'(kv_cnt - kv0), 32'd1);
    chk("ign_code",  32'(key_code), 32'd13);
    chk("ign_entry", 32'(entry), 32'h0012);
    chk("ign_err",   32'(err_cnt - er0), 32'd0);
    press(4'd11);
    chk("clr_entry", 32'(entry), 32'h0);
    chk("clr_count", 32'(digit_count), 32'd0);

    // overflow: err only on the 5th digit
    er0 = err_cnt;
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    chk("t3_err4", 32'(err_cnt - er0), 32'd0);
    press(4'd5);
    chk("t3_entry", 32'(entry), 32'h9876);
    chk("t3_count", 32'(digit_count), 32'd4);
    chk("t3_err5",  32'(err_cnt - er0), 32'd1);
    press(4'd11);

    // START / BACKSPACE on empty buffer
    er0 = err_cnt;
    press(4'd10);
    chk("t5_err",   32'(err_cnt - er0), 32'd1);
    chk("t5_req",   32'(start_req), 32'd0);
    press(4'd12);
    chk("bs0_err",   32'(err_cnt - er0), 32'd2);
    chk("bs0_count", 32'(digit_count), 32'd0);

    // stray ack while idle is ignored
    press(4'd4);
    start_ack = 1'b1;
    repeat (3) @(negedge clk);
    start_ack = 1'b0;
    chk("ack_idle_entry", 32'(entry), 32'h0004);
    chk("ack_idle_req",   32'(start_req), 32'd0);

    // handshake with entry 0042; keypad ignored while waiting
    press(4'd2);
    kv0 = kv_cnt;
    key = 4'd10; keydown = 1'b1;
    repeat (10) @(negedge clk);
    keydown = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2)  begin key = 4'd7; keydown = 1'b1; end
      if (i == 12) keydown = 1'b0;
      @(negedge clk);
      if (start_req && entry == 16'h0042 && digit_count == 4'd2) hi++;
    end
    chk("t4_hi",  32'(hi), 32'd20);
    chk("t4_kv",  32'(kv_cnt - kv0), 32'd1);
    start_ack = 1'b1;
    @(negedge clk);
    start_ack = 1'b0;
    chk("t4_req",   32'(start_req), 32'd0);
    chk("t4_entry", 32'(entry), 32'h0);
    chk("t4_count", 32'(digit_count), 32'd0);
    repeat (10) @(negedge clk);

    // async reset while waiting for ack
    press(4'd1);
    key = 4'd10; keydown = 1'b1;
    repeat (10) @(negedge clk);
    keydown = 1'b0;
    @(negedge clk);
    chk("t6_req_pre", 32'(start_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // async reset mid-press; the held key must not be accepted afterwards
    press(4'd3);
    chk("t6_pre_entry", 32'(entry), 32'h0003);
    key = 4'd5; keydown = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_rst_press");
    @(negedge clk);
    rst_n = 1'b1;
    kv0 = kv_cnt;
    repeat (20) @(negedge clk);
    chk("t6_held_kv",    32'(kv_cnt - kv0), 32'd0);
    chk("t6_held_entry", 32'(entry), 32'h0);
    keydown = 1'b0;
    repeat (10) @(negedge clk);
    press(4'd5);
    chk("t6_fresh_kv",    32'(kv_cnt - kv0), 32'd1);
    chk("t6_fresh_entry", 32'(entry), 32'h0005);
    chk("t6_fresh_count", 32'(digit_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
